// File: rtl/lsu_mem_port.sv
// Load/store unit bridging the M stage to a variable-latency data memory with a
// req/ack handshake, store lane formatting, load extension and fault reporting.
module lsu_mem_port #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid_m,
    input  logic              i_mem_write,
    input  logic [4:0]        i_mem_src,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall_m,
    output logic [31:0]       o_rdata_m,
    output logic              o_done,
    output logic [1:0]        o_fault,
    output logic              o_req,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [3:0]        o_be,
    output logic [31:0]       o_wdata,
    input  logic              i_ack,
    input  logic [31:0]       i_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_off;
    logic [4:0]          r_src;
    logic                r_we;
    logic [3:0]          r_be;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic [1:0]          r_fault;

    logic                w_illegal;
    logic                w_misal;
    logic                w_half;
    logic                w_timeout;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_hword;
    logic [31:0]         w_load;

    // i_mem_src = {memb, memh, lw, membu, memhu}
    assign w_illegal = !$onehot(i_mem_src) || (i_mem_write && (i_mem_src[1] || i_mem_src[0]));
    assign w_half    = i_mem_src[3] | i_mem_src[0];
    assign w_misal   = (w_half && i_addr[0]) || (i_mem_src[2] && (i_addr[1:0] != 2'b00));
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        if (i_mem_write) begin
            if (i_mem_src[4]) begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end else if (i_mem_src[3]) begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
        end
    end

    always_comb begin
        w_byte  = '0;
        w_hword = r_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_load  = '0;
        case (r_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        if (!r_we) begin
            case (r_src)
                5'b10000: w_load = {{24{w_byte[7]}}, w_byte};
                5'b01000: w_load = {{16{w_hword[15]}}, w_hword};
                5'b00100: w_load = i_rdata;
                5'b00010: w_load = {24'd0, w_byte};
                5'b00001: w_load = {16'd0, w_hword};
                default:  w_load = '0;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_valid_m) w_next = (w_illegal || w_misal) ? ST_RESP : ST_BUS;
            ST_BUS:  if (i_ack || w_timeout) w_next = ST_RESP;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_off   <= '0;
            r_src   <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fault <= 2'b00;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (i_valid_m) begin
                        if (w_illegal) begin
                            r_fault <= 2'b11;
                            r_rdata <= '0;
                        end else if (w_misal) begin
                            r_fault <= 2'b01;
                            r_rdata <= '0;
                        end else begin
                            r_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                            r_we    <= i_mem_write;
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_off   <= i_addr[1:0];
                            r_src   <= i_mem_src;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    // An ack in the final timeout cycle still completes normally.
                    if (i_ack) begin
                        r_rdata <= w_load;
                        r_fault <= 2'b00;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_fault <= 2'b10;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req     = (r_state == ST_BUS);
    assign o_done    = (r_state == ST_RESP);
    assign o_stall_m = i_valid_m && (r_state != ST_RESP);
    assign o_we      = r_we;
    assign o_be      = r_be;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_rdata_m = r_rdata;
    assign o_fault   = r_fault;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed vector table, reset corner case
// and randomized accesses checked against a byte-level reference model.
module tb_lsu_mem_port;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid_m;
    logic        i_mem_write;
    logic [4:0]  i_mem_src;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall_m;
    logic [31:0] o_rdata_m;
    logic        o_done;
    logic [1:0]  o_fault;
    logic        o_req;
    logic        o_we;
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wdata;
    logic        i_ack;
    logic [31:0] i_rdata;

    int total = 0;
    int bad   = 0;

    lsu_mem_port #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .i_valid_m(i_valid_m), .i_mem_write(i_mem_write),
        .i_mem_src(i_mem_src), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_stall_m(o_stall_m), .o_rdata_m(o_rdata_m), .o_done(o_done),
        .o_fault(o_fault), .o_req(o_req), .o_we(o_we), .o_addr(o_addr),
        .o_be(o_be), .o_wdata(o_wdata), .i_ack(i_ack), .i_rdata(i_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fault;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          nreq;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [4:0]  src;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          delay;
        exp_t        e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Byte-lane reference: sizes, lane offsets and masks from plain arithmetic.
    function automatic exp_t model(input logic wr, input logic [4:0] src, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rd, input int delay);
        exp_t    e;
        int      size;
        int      off;
        bit      sgn;
        longint  mask;
        longint  v;
        logic [31:0] w;
        e.fault = 2'd0; e.rdata = 32'd0; e.be = 4'hF; e.wdata = wd; e.nreq = 0;
        if ($countones(src) != 1 || (wr && (src[1] || src[0]))) begin
            e.fault = 2'd3;
            return e;
        end
        size = (src[4] || src[1]) ? 1 : ((src[3] || src[0]) ? 2 : 4);
        sgn  = src[4] || src[3];
        if ((addr % size) != 0) begin
            e.fault = 2'd1;
            return e;
        end
        off  = int'(addr % 4);
        mask = (64'd1 << (8 * size)) - 1;
        if (wr) begin
            e.be = 4'((1 << size) - 1) << off;
            for (int k = 0; k < 4; k++) begin
                w = wd >> (8 * (k % size));
                e.wdata[8*k +: 8] = w[7:0];
            end
        end
        if (delay >= TO) begin
            e.fault = 2'd2;
            e.nreq  = TO;
        end else begin
            e.nreq = delay + 1;
            if (!wr) begin
                v = (longint'(rd) >> (8 * off)) & mask;
                if (sgn && v[8*size-1]) v = v | ~mask;
                e.rdata = v[31:0];
            end
        end
        return e;
    endfunction

    // Starts just after a rising edge; leaves i_valid_m low just after the edge ending RESP.
    task automatic run_op(input string nm, input logic wr, input logic [4:0] src,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int delay, input exp_t e);
        int nreq = 0;
        bit done_seen = 0;
        i_valid_m = 1'b1; i_mem_write = wr; i_mem_src = src; i_addr = addr;
        i_wdata = wd; i_rdata = rd; i_ack = 1'b0;
        for (int cyc = 0; cyc < 20 && !done_seen; cyc++) begin
            @(negedge clk);
            if (o_done) begin
                done_seen = 1;
                i_ack = 1'b0;
                chk({nm, " done_cycle"}, 32'(cyc), 32'(1 + e.nreq));
                chk({nm, " fault"}, 32'(o_fault), 32'(e.fault));
                chk({nm, " rdata"}, o_rdata_m, e.rdata);
                chk({nm, " resp_stall"}, 32'(o_stall_m), 32'd0);
                chk({nm, " resp_req"}, 32'(o_req), 32'd0);
            end else begin
                chk({nm, " stall"}, 32'(o_stall_m), 32'd1);
                if (o_req) begin
                    nreq++;
                    chk({nm, " addr"}, o_addr, addr & 32'hFFFF_FFFC);
                    chk({nm, " we"}, 32'(o_we), 32'(wr));
                    chk({nm, " be"}, 32'(o_be), 32'(e.be));
                    if (wr) chk({nm, " wdata"}, o_wdata, e.wdata);
                    i_ack = (nreq - 1 == delay);
                end else begin
                    i_ack = 1'b0;
                end
            end
        end
        if (!done_seen) begin
            total++; bad++;
            $display("FAIL %s done_wait: got no o_done within 20 cycles, want one", nm);
        end
        chk({nm, " req_cycles"}, 32'(nreq), 32'(e.nreq));
        @(posedge clk); #1;
        i_ack = 1'b0;
        i_valid_m = 1'b0;
    endtask

    function automatic exp_t mk(input logic [1:0] f, input logic [31:0] r, input logic [3:0] be,
                                input logic [31:0] wd, input int n);
        exp_t e;
        e.fault = f; e.rdata = r; e.be = be; e.wdata = wd; e.nreq = n;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        exp_t e;
        logic        wr;
        logic [4:0]  src;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;

        vecs[0]  = '{1'b0, 5'b00100, 32'h0000_1008, 32'h0, 32'hDEAD_BEEF, 0,  mk(2'd0, 32'hDEAD_BEEF, 4'hF, 32'h0, 1)};
        vecs[1]  = '{1'b0, 5'b10000, 32'h0000_0003, 32'h0, 32'h8081_F27F, 0,  mk(2'd0, 32'hFFFF_FF80, 4'hF, 32'h0, 1)};
        vecs[2]  = '{1'b0, 5'b00010, 32'h0000_0003, 32'h0, 32'h8081_F27F, 0,  mk(2'd0, 32'h0000_0080, 4'hF, 32'h0, 1)};
        vecs[3]  = '{1'b0, 5'b01000, 32'h0000_0002, 32'h0, 32'h8081_F27F, 0,  mk(2'd0, 32'hFFFF_8081, 4'hF, 32'h0, 1)};
        vecs[4]  = '{1'b0, 5'b00001, 32'h0000_0000, 32'h0, 32'h8081_F27F, 0,  mk(2'd0, 32'h0000_F27F, 4'hF, 32'h0, 1)};
        vecs[5]  = '{1'b1, 5'b10000, 32'h0000_0002, 32'h1234_5678, 32'hAAAA_AAAA, 0, mk(2'd0, 32'h0, 4'b0100, 32'h7878_7878, 1)};
        vecs[6]  = '{1'b1, 5'b01000, 32'h0000_0002, 32'h1234_5678, 32'hAAAA_AAAA, 3, mk(2'd0, 32'h0, 4'b1100, 32'h5678_5678, 4)};
        vecs[7]  = '{1'b0, 5'b00100, 32'h0000_1002, 32'h0, 32'h1111_1111, 0,  mk(2'd1, 32'h0, 4'hF, 32'h0, 0)};
        vecs[8]  = '{1'b1, 5'b00010, 32'h0000_0000, 32'h0, 32'h1111_1111, 0,  mk(2'd3, 32'h0, 4'hF, 32'h0, 0)};
        vecs[9]  = '{1'b0, 5'b00110, 32'h0000_0000, 32'h0, 32'h1111_1111, 0,  mk(2'd3, 32'h0, 4'hF, 32'h0, 0)};
        vecs[10] = '{1'b0, 5'b00100, 32'h0000_2000, 32'h0, 32'h5555_AAAA, 99, mk(2'd2, 32'h0, 4'hF, 32'h0, 4)};
        vecs[11] = '{1'b0, 5'b00100, 32'h0000_2004, 32'h0, 32'h5555_AAAA, 3,  mk(2'd0, 32'h5555_AAAA, 4'hF, 32'h0, 4)};
        vecs[12] = '{1'b1, 5'b00100, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 1,  mk(2'd0, 32'h0, 4'hF, 32'hCAFE_F00D, 2)};

        rst = 1'b1; i_valid_m = 1'b0; i_mem_write = 1'b0; i_mem_src = '0;
        i_addr = '0; i_wdata = '0; i_ack = 1'b0; i_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req", 32'(o_req), 32'd0);
        chk("rst done", 32'(o_done), 32'd0);
        chk("rst we", 32'(o_we), 32'd0);
        chk("rst be", 32'(o_be), 32'd0);
        chk("rst addr", o_addr, 32'd0);
        chk("rst wdata", o_wdata, 32'd0);
        chk("rst rdata", o_rdata_m, 32'd0);
        chk("rst fault", 32'(o_fault), 32'd0);
        chk("rst stall_lo", 32'(o_stall_m), 32'd0);
        i_valid_m = 1'b1;
        #1 chk("rst stall_hi", 32'(o_stall_m), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; i_valid_m = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("idle stall", 32'(o_stall_m), 32'd0);
            chk("idle req", 32'(o_req), 32'd0);
        end
        @(posedge clk); #1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].wr, vecs[i].src, vecs[i].addr,
                   vecs[i].wd, vecs[i].rd, vecs[i].delay, vecs[i].e);

        // Reset during the second BUS cycle, then a late ack.
        i_valid_m = 1'b1; i_mem_write = 1'b0; i_mem_src = 5'b00100;
        i_addr = 32'h0000_0040; i_rdata = 32'h0BAD_0BAD; i_ack = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("rbus req1", 32'(o_req), 32'd1);
        @(negedge clk); chk("rbus req2", 32'(o_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rbus req_after", 32'(o_req), 32'd0);
        chk("rbus done_after", 32'(o_done), 32'd0);
        chk("rbus stall_follow", 32'(o_stall_m), 32'd1);
        rst = 1'b0; i_valid_m = 1'b0; i_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rbus late_done", 32'(o_done), 32'd0);
            chk("rbus late_req", 32'(o_req), 32'd0);
            chk("rbus late_stall", 32'(o_stall_m), 32'd0);
        end
        @(posedge clk); #1;
        i_ack = 1'b0;

        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) src = 5'b00001 << $urandom_range(0, 4);
            else                          src = 5'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wd  = $urandom;
            rd  = $urandom;
            dly = $urandom_range(0, 5);
            e   = model(wr, src, addr, wd, rd, dly);
            run_op($sformatf("rnd%0d", n), wr, src, addr, wd, rd, dly, e);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("rnd gap_stall", 32'(o_stall_m), 32'd0);
                chk("rnd gap_req", 32'(o_req), 32'd0);
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
